// File: rtl/flexpipe_pkg.sv
// Shared types for the flexpipe memory subsystem.
//   mem_req_t        : request beat presented to the memory arbiter
//   mem_resp_t       : response beat returned by the memory arbiter
//   pf_sched_state_t : prefetch_scheduler FSM states
// `REQ_ID_WIDTH sets the request/response id width; the arbiter owns the id MSB.

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif

package flexpipe_pkg;

  localparam int unsigned MemAddrW = 32;
  localparam int unsigned MemDataW = 32;

  typedef struct packed {
    logic [MemAddrW-1:0]      addr;
    logic [`REQ_ID_WIDTH-1:0] id;
    logic                     we;
    logic [2:0]               size;
  } mem_req_t;

  typedef struct packed {
    logic [MemDataW-1:0]      rdata;
    logic [`REQ_ID_WIDTH-1:0] id;
    logic                     last;
    logic                     err;
  } mem_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } pf_sched_state_t;

endpackage

// File: rtl/pf_credit_counter.sv
// Saturating, underflow-guarded credit counter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc, dec   : request one credit taken / one credit returned
//   count      : current credits in use (0..MAX)
//   full       : count == MAX; further inc is dropped unless a dec lands too
//   empty      : count == 0
//   underflow  : dec seen while empty (the dec is dropped)

module pf_credit_counter #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         underflow
);

  logic [W-1:0] count_q, count_d;
  logic         dec_ok, inc_ok;

  assign full      = (count_q == W'(MAX));
  assign empty     = (count_q == '0);
  assign underflow = dec && empty;
  assign dec_ok    = dec && !empty;
  // A full counter may still take an inc in the same cycle a credit comes back.
  assign inc_ok    = inc && (!full || dec_ok);
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + W'(1);
      2'b01:   count_d = count_q - W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prefetch_scheduler.sv
// Tile prefetch sequencer feeding the low-priority prefetch port of the arbiter.
// Accepts a (base, lines) descriptor, issues one line read per request while the
// active core is idle and credits remain, waits for all last beats, then pulses
// tile_done (tile_aborted marks tiles cut short by abort).
//   clk, rst_n                    : clock, synchronous active-low reset
//   desc_valid/ready/base/lines   : tile descriptor handshake
//   abort                         : stop the current tile (ignored when idle)
//   active_idle                   : arbiter reports no active-core traffic
//   pf_req/_valid/_ready          : prefetch request channel
//   pf_resp/_valid                : response beats (credit returned on last)
//   busy, outstanding             : status
//   tile_done, tile_aborted       : completion pulse and its qualifier
//   spurious_resp                 : sticky, last beat seen with nothing in flight

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif

module prefetch_scheduler
  import flexpipe_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned LINE_BYTES      = 64,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_lines,
  input  logic              abort,
  input  logic              active_idle,
  output mem_req_t          pf_req,
  output logic              pf_req_valid,
  input  logic              pf_req_ready,
  input  mem_resp_t         pf_resp,
  input  logic              pf_resp_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  outstanding,
  output logic              tile_done,
  output logic              tile_aborted,
  output logic              spurious_resp
);

  localparam int unsigned LineShift = $clog2(LINE_BYTES);
  localparam int unsigned IdLowW    = `REQ_ID_WIDTH - 1;

  pf_sched_state_t state_q, state_d;

  logic [ADDR_W-1:0]        base_q;
  logic [LEN_W-1:0]         lines_q, issued_q, issued_inc;
  logic                     abort_q, hold_q, spurious_q;
  logic                     desc_hs, launch, req_valid, req_hs, resp_last, drain_zero;
  logic                     credit_full, credit_empty, credit_underflow;
  logic [ADDR_W-1:0]        addr_calc;
  logic [`REQ_ID_WIDTH-1:0] id_calc;

  // Response payload is only inspected for the last flag.
  logic unused_resp;
  assign unused_resp = ^{pf_resp.rdata, pf_resp.id, pf_resp.err};

  assign desc_hs    = desc_valid && desc_ready;
  assign resp_last  = pf_resp_valid && pf_resp.last;
  assign issued_inc = issued_q + LEN_W'(1);

  // A fresh request only starts when nothing is pending; a pending one is held
  // (hold_q) regardless of credits, active_idle or abort.
  assign launch    = (state_q == ISSUE) && !hold_q && !credit_full && active_idle &&
                     (issued_q < lines_q) && !abort_q;
  assign req_valid = (state_q == ISSUE) && (hold_q || launch);
  assign req_hs    = req_valid && pf_req_ready;

  // Request fields derive from registered state only, so they stay stable while held.
  assign addr_calc = base_q + (ADDR_W'(issued_q) << LineShift);
  assign id_calc   = {1'b0, IdLowW'(issued_q)};

  // Outstanding reaching zero this cycle (DRAIN never issues, so only a dec matters).
  assign drain_zero = credit_empty || ((outstanding == CNT_W'(1)) && resp_last);

  pf_credit_counter #(
    .MAX(MAX_OUTSTANDING),
    .W  (CNT_W)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (req_hs),
    .dec      (resp_last),
    .count    (outstanding),
    .full     (credit_full),
    .empty    (credit_empty),
    .underflow(credit_underflow)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (desc_hs) begin
          state_d = (desc_lines == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if ((req_hs && (issued_inc == lines_q)) || (abort_q && !req_valid)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_zero) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    desc_ready   = 1'b0;
    busy         = 1'b0;
    tile_done    = 1'b0;
    tile_aborted = 1'b0;
    pf_req_valid = 1'b0;
    pf_req       = '0;
    unique case (state_q)
      IDLE: desc_ready = rst_n;  // held low while reset is asserted
      ISSUE: begin
        busy         = 1'b1;
        pf_req_valid = req_valid;
        if (req_valid) begin
          pf_req.addr = MemAddrW'(addr_calc);
          pf_req.id   = id_calc;
        end
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        busy         = 1'b1;
        tile_done    = 1'b1;
        tile_aborted = abort_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign spurious_resp = spurious_q;

  // Tile datapath and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q     <= '0;
      lines_q    <= '0;
      issued_q   <= '0;
      abort_q    <= 1'b0;
      hold_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (desc_hs && (desc_lines != '0)) begin
        base_q   <= desc_base;
        lines_q  <= desc_lines;
        issued_q <= '0;
      end else if (req_hs) begin
        issued_q <= issued_inc;
      end
      hold_q <= req_valid && !pf_req_ready;
      if (state_q == DONE) begin
        abort_q <= 1'b0;
      end else if (abort && ((state_q == ISSUE) || (state_q == DRAIN))) begin
        abort_q <= 1'b1;
      end
      spurious_q <= spurious_q || credit_underflow;
    end
  end

endmodule

// File: tb/tb_prefetch_scheduler.sv
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif

module tb_prefetch_scheduler;
  import flexpipe_pkg::*;

  localparam int unsigned MaxA  = 8;
  localparam int unsigned MaxB  = 2;
  localparam int unsigned CntWA = $clog2(MaxA + 1);
  localparam int unsigned CntWB = $clog2(MaxB + 1);

  logic        clk;
  logic        rst_n;
  logic        desc_valid;
  logic [31:0] desc_base;
  logic [15:0] desc_lines;
  logic        abort;
  logic        active_idle;
  logic        pf_req_ready;
  mem_resp_t   pf_resp;
  logic        pf_resp_valid;

  logic             a_desc_ready, a_pf_req_valid, a_busy, a_tile_done, a_tile_aborted, a_spur;
  mem_req_t         a_pf_req;
  logic [CntWA-1:0] a_outstanding;
  logic             b_desc_ready, b_pf_req_valid, b_busy, b_tile_done, b_tile_aborted, b_spur;
  mem_req_t         b_pf_req;
  logic [CntWB-1:0] b_outstanding;

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prefetch_scheduler #(.MAX_OUTSTANDING(MaxA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(a_desc_ready),
    .desc_base(desc_base), .desc_lines(desc_lines), .abort(abort), .active_idle(active_idle),
    .pf_req(a_pf_req), .pf_req_valid(a_pf_req_valid), .pf_req_ready(pf_req_ready),
    .pf_resp(pf_resp), .pf_resp_valid(pf_resp_valid), .busy(a_busy),
    .outstanding(a_outstanding), .tile_done(a_tile_done), .tile_aborted(a_tile_aborted),
    .spurious_resp(a_spur)
  );

  prefetch_scheduler #(.MAX_OUTSTANDING(MaxB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(b_desc_ready),
    .desc_base(desc_base), .desc_lines(desc_lines), .abort(abort), .active_idle(active_idle),
    .pf_req(b_pf_req), .pf_req_valid(b_pf_req_valid), .pf_req_ready(pf_req_ready),
    .pf_resp(pf_resp), .pf_resp_valid(pf_resp_valid), .busy(b_busy),
    .outstanding(b_outstanding), .tile_done(b_tile_done), .tile_aborted(b_tile_aborted),
    .spurious_resp(b_spur)
  );

  // ---------------------------------------------------------------- reference model
  // phase: 0 waiting for a tile, 1 fetching lines, 2 waiting for last beats, 3 done pulse
  typedef struct {
    int unsigned     phase;
    longint unsigned base;
    int unsigned     lines;
    int unsigned     issued;
    int unsigned     inflight;
    bit              stop;
    bit              pending;
    bit              spur;
  } model_t;

  typedef struct {
    bit              desc_ready, req_valid, busy, done, aborted, spur;
    longint unsigned addr;
    int unsigned     id, inflight;
  } mout_t;

  model_t ma, mb;

  function automatic mout_t m_out(model_t m, int unsigned cap);
    mout_t o = '{default: 0};
    o.desc_ready = rst_n && (m.phase == 0);
    o.busy       = (m.phase != 0);
    o.done       = (m.phase == 3);
    o.aborted    = (m.phase == 3) && m.stop;
    o.spur       = m.spur;
    o.inflight   = m.inflight;
    o.req_valid  = (m.phase == 1) && (m.pending || ((m.inflight < cap) && (active_idle == 1'b1) &&
                   (m.issued < m.lines) && !m.stop));
    if (o.req_valid) begin
      o.addr = (m.base + 64 * longint'(m.issued)) % 64'h1_0000_0000;
      o.id   = m.issued % 128;
    end
    return o;
  endfunction

  function automatic model_t m_next(model_t m, bit req_valid);
    model_t n = m;
    bit hs, lastb;
    if (rst_n !== 1'b1) begin
      n = '{default: 0};
    end else begin
      hs    = req_valid && (pf_req_ready == 1'b1);
      lastb = (pf_resp_valid == 1'b1) && (pf_resp.last == 1'b1);
      if (lastb && m.inflight == 0) n.spur = 1'b1;
      n.inflight = m.inflight + (hs ? 1 : 0) - ((lastb && m.inflight > 0) ? 1 : 0);
      case (m.phase)
        0: if (desc_valid == 1'b1) begin
          if (desc_lines == 0) n.phase = 3;
          else begin
            n.phase  = 1;
            n.base   = longint'(desc_base);
            n.lines  = desc_lines;
            n.issued = 0;
          end
        end
        1: begin
          if (abort == 1'b1) n.stop = 1'b1;
          n.issued  = m.issued + (hs ? 1 : 0);
          n.pending = req_valid && !hs;
          if ((hs && (m.issued + 1 == m.lines)) || (m.stop && !req_valid)) n.phase = 2;
        end
        2: begin
          if (abort == 1'b1) n.stop = 1'b1;
          if (n.inflight == 0) n.phase = 3;
        end
        default: begin
          n.phase = 0;
          n.stop  = 1'b0;
        end
      endcase
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_defaults();
    desc_valid    = 1'b0;
    desc_base     = '0;
    desc_lines    = '0;
    abort         = 1'b0;
    active_idle   = 1'b1;
    pf_req_ready  = 1'b1;
    pf_resp       = '0;
    pf_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_defaults();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_desc(input logic [31:0] base, input logic [15:0] lines);
    desc_valid = 1'b1;
    desc_base  = base;
    desc_lines = lines;
    tick();
    desc_valid = 1'b0;
  endtask

  function automatic logic [63:0] pack(logic dr, logic v, logic b, logic d, logic ab, logic sp,
                                       logic [7:0] o, mem_req_t r);
    return 64'({dr, v, b, d, ab, sp, o, r});
  endfunction

  function automatic mem_req_t exp_req(mout_t e);
    mem_req_t r = '0;
    r.addr = 32'(e.addr);
    r.id   = 8'(e.id);
    return r;
  endfunction

  typedef struct {
    bit          dv;
    logic [31:0] base;
    logic [15:0] lines;
    bit          rdy, idle, rv, rl;
    bit          e_dr, e_v;
    logic [31:0] e_addr;
    logic [7:0]  e_id;
    logic [3:0]  e_out;
    bit          e_done, e_busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Basic tile: base 0x1000, 4 lines, each last beat 3 cycles after its handshake.
    //            dv base        lines  rdy idle rv rl | dr v  addr          id    out  done busy
    tbl[0] = '{1, 32'h1000, 16'd4, 1, 1, 0, 0, 1, 0, 32'h0,    8'd0, 4'd0, 0, 0};
    tbl[1] = '{0, 32'h0,    16'd0, 1, 1, 0, 0, 0, 1, 32'h1000, 8'd0, 4'd0, 0, 1};
    tbl[2] = '{0, 32'h0,    16'd0, 1, 1, 0, 0, 0, 1, 32'h1040, 8'd1, 4'd1, 0, 1};
    tbl[3] = '{0, 32'h0,    16'd0, 1, 1, 0, 0, 0, 1, 32'h1080, 8'd2, 4'd2, 0, 1};
    tbl[4] = '{0, 32'h0,    16'd0, 1, 1, 1, 1, 0, 1, 32'h10C0, 8'd3, 4'd3, 0, 1};
    tbl[5] = '{0, 32'h0,    16'd0, 1, 1, 1, 1, 0, 0, 32'h0,    8'd0, 4'd3, 0, 1};
    tbl[6] = '{0, 32'h0,    16'd0, 1, 1, 1, 1, 0, 0, 32'h0,    8'd0, 4'd2, 0, 1};
    tbl[7] = '{0, 32'h0,    16'd0, 1, 1, 1, 1, 0, 0, 32'h0,    8'd0, 4'd1, 0, 1};
    tbl[8] = '{0, 32'h0,    16'd0, 1, 1, 0, 0, 0, 0, 32'h0,    8'd0, 4'd0, 1, 1};
    tbl[9] = '{0, 32'h0,    16'd0, 1, 1, 0, 0, 1, 0, 32'h0,    8'd0, 4'd0, 0, 0};

    // Reset state.
    rst_n = 1'b0;
    drv_defaults();
    #1;
    chk("desc_ready low in reset", a_desc_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset desc_ready", a_desc_ready, 1);
    chk("reset pf_req_valid", a_pf_req_valid, 0);
    chk("reset pf_req", a_pf_req, 0);
    chk("reset busy", a_busy, 0);
    chk("reset outstanding", a_outstanding, 0);
    chk("reset tile_done", a_tile_done, 0);
    chk("reset tile_aborted", a_tile_aborted, 0);
    chk("reset spurious", a_spur, 0);

    // Table-driven basic tile (includes a handshake coinciding with a last beat).
    foreach (tbl[i]) begin
      desc_valid    = tbl[i].dv;
      desc_base     = tbl[i].base;
      desc_lines    = tbl[i].lines;
      pf_req_ready  = tbl[i].rdy;
      active_idle   = tbl[i].idle;
      pf_resp       = '0;
      pf_resp.last  = tbl[i].rl;
      pf_resp_valid = tbl[i].rv;
      #1;
      chk($sformatf("tbl%0d desc_ready", i), a_desc_ready, tbl[i].e_dr);
      chk($sformatf("tbl%0d pf_req_valid", i), a_pf_req_valid, tbl[i].e_v);
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d addr", i), a_pf_req.addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d id", i), a_pf_req.id, tbl[i].e_id);
      end
      chk($sformatf("tbl%0d outstanding", i), a_outstanding, tbl[i].e_out);
      chk($sformatf("tbl%0d tile_done", i), a_tile_done, tbl[i].e_done);
      chk($sformatf("tbl%0d tile_aborted", i), a_tile_aborted, 0);
      chk($sformatf("tbl%0d busy", i), a_busy, tbl[i].e_busy);
      tick();
    end

    // Credit limit on the 2-credit instance: 5 lines, responses withheld.
    do_reset();
    send_desc(32'h2000, 16'd5);
    #1; chk("credit c1 valid", b_pf_req_valid, 1); tick();
    #1; chk("credit c2 valid", b_pf_req_valid, 1); tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("credit stall valid", b_pf_req_valid, 0);
      chk("credit stall outstanding", b_outstanding, 2);
      if (k == 1) begin
        pf_resp_valid = 1'b1;
        pf_resp.last  = 1'b1;
      end
      tick();
    end
    pf_resp_valid = 1'b0;
    #1;
    chk("credit release valid", b_pf_req_valid, 1);
    chk("credit release addr", b_pf_req.addr, 32'h2080);
    chk("credit release outstanding", b_outstanding, 1);

    // Backpressure with active_idle dropped mid-stall.
    do_reset();
    send_desc(32'h3000, 16'd2);
    pf_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) active_idle = 1'b0;
      #1;
      chk($sformatf("stall%0d valid", k), a_pf_req_valid, 1);
      chk($sformatf("stall%0d addr", k), a_pf_req.addr, 32'h3000);
      chk($sformatf("stall%0d id", k), a_pf_req.id, 0);
      tick();
    end
    pf_req_ready = 1'b1;
    #1; chk("stall accept valid", a_pf_req_valid, 1); tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("gated valid", a_pf_req_valid, 0);
      chk("gated outstanding", a_outstanding, 1);
      tick();
    end
    active_idle = 1'b1;
    #1;
    chk("ungated valid", a_pf_req_valid, 1);
    chk("ungated addr", a_pf_req.addr, 32'h3040);
    chk("ungated id", a_pf_req.id, 1);

    // Abort after 3 handshakes.
    do_reset();
    send_desc(32'h4000, 16'd10);
    tick(); tick(); tick();
    active_idle = 1'b0;
    abort       = 1'b1;
    #1;
    chk("abort valid", a_pf_req_valid, 0);
    chk("abort outstanding", a_outstanding, 3);
    tick();
    abort       = 1'b0;
    active_idle = 1'b1;
    #1; chk("aborted no issue", a_pf_req_valid, 0); tick();
    pf_resp_valid = 1'b1;
    pf_resp.last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("abort drain%0d valid", k), a_pf_req_valid, 0);
      chk($sformatf("abort drain%0d done", k), a_tile_done, 0);
      tick();
    end
    pf_resp_valid = 1'b0;
    #1;
    chk("abort tile_done", a_tile_done, 1);
    chk("abort tile_aborted", a_tile_aborted, 1);
    chk("abort outstanding end", a_outstanding, 0);
    tick();
    #1;
    chk("abort done one cycle", a_tile_done, 0);
    chk("abort back idle", a_desc_ready, 1);

    // Zero-line tile.
    do_reset();
    send_desc(32'h5000, 16'd0);
    #1;
    chk("zero done", a_tile_done, 1);
    chk("zero aborted", a_tile_aborted, 0);
    chk("zero valid", a_pf_req_valid, 0);
    chk("zero desc_ready", a_desc_ready, 0);
    tick();
    #1;
    chk("zero done one cycle", a_tile_done, 0);
    chk("zero idle", a_desc_ready, 1);

    // Address wrap.
    do_reset();
    send_desc(32'hFFFF_FFC0, 16'd2);
    #1;
    chk("wrap addr0", a_pf_req.addr, 32'hFFFF_FFC0);
    chk("wrap valid0", a_pf_req_valid, 1);
    tick();
    #1;
    chk("wrap addr1", a_pf_req.addr, 32'h0);
    chk("wrap id1", a_pf_req.id, 1);
    tick();
    #1; chk("wrap no third", a_pf_req_valid, 0);

    // Spurious last beat.
    do_reset();
    pf_resp_valid = 1'b1;
    tick();
    pf_resp_valid = 1'b0;
    #1; chk("non-last no spurious", a_spur, 0);
    pf_resp_valid = 1'b1;
    pf_resp.last  = 1'b1;
    tick();
    pf_resp_valid = 1'b0;
    #1;
    chk("spurious set", a_spur, 1);
    chk("spurious no underflow", a_outstanding, 0);
    tick(); tick(); tick();
    #1; chk("spurious sticky", a_spur, 1);

    // Reset mid-ISSUE, then a stale response.
    do_reset();
    send_desc(32'h6000, 16'd8);
    tick(); tick();
    rst_n = 1'b0;
    #1; chk("midreset desc_ready", a_desc_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midreset busy", a_busy, 0);
    chk("midreset outstanding", a_outstanding, 0);
    chk("midreset valid", a_pf_req_valid, 0);
    chk("midreset desc_ready1", a_desc_ready, 1);
    pf_resp_valid = 1'b1;
    pf_resp.last  = 1'b1;
    tick();
    pf_resp_valid = 1'b0;
    #1; chk("stale resp spurious", a_spur, 1);

    // Randomized run against the reference model, both credit depths.
    do_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    for (int c = 0; c < 4000; c++) begin
      mout_t ea, eb;
      mem_req_t ra, rb;
      rst_n         = ($urandom_range(0, 199) != 0);
      desc_valid    = ($urandom_range(0, 3) == 0);
      desc_base     = $urandom;
      desc_lines    = 16'($urandom_range(0, 6));
      abort         = ($urandom_range(0, 40) == 0);
      active_idle   = ($urandom_range(0, 4) != 0);
      pf_req_ready  = ($urandom_range(0, 2) != 0);
      pf_resp       = '0;
      pf_resp.rdata = $urandom;
      pf_resp.id    = 8'($urandom);
      pf_resp.last  = ($urandom_range(0, 1) == 1);
      pf_resp_valid = (ma.inflight > 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 30) == 0);
      #1;
      ea = m_out(ma, MaxA);
      eb = m_out(mb, MaxB);
      ra = a_pf_req_valid ? a_pf_req : '0;
      rb = b_pf_req_valid ? b_pf_req : '0;
      chk($sformatf("rand A cyc%0d", c),
          pack(a_desc_ready, a_pf_req_valid, a_busy, a_tile_done, a_tile_aborted, a_spur,
               8'(a_outstanding), ra),
          pack(ea.desc_ready, ea.req_valid, ea.busy, ea.done, ea.aborted, ea.spur,
               8'(ea.inflight), exp_req(ea)));
      chk($sformatf("rand B cyc%0d", c),
          pack(b_desc_ready, b_pf_req_valid, b_busy, b_tile_done, b_tile_aborted, b_spur,
               8'(b_outstanding), rb),
          pack(eb.desc_ready, eb.req_valid, eb.busy, eb.done, eb.aborted, eb.spur,
               8'(eb.inflight), exp_req(eb)));
      ma = m_next(ma, ea.req_valid);
      mb = m_next(mb, eb.req_valid);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
